// File: rtl/ram_pkg.sv
// Shared defaults, FSM state encoding and command payload for the RAM port front-end.
package ram_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned ADDR_WIDTH = 3;
   localparam int unsigned DEPTH      = 8;
   localparam int unsigned CNT_WIDTH  = 16;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAPT,
      ERR,
      RESP
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/stat_counter.sv
// Free-running wrapping event counter with asynchronous active-high reset.
module stat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ram_port_ctrl.sv
// Valid/ready command front-end for one port of the shared dual-port RAM:
// issues one access at a time and returns read data on a response channel.
module ram_port_ctrl #(
   parameter int unsigned DATA_WIDTH = ram_pkg::DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
   parameter int unsigned DEPTH      = ram_pkg::DEPTH,
   parameter int unsigned CNT_WIDTH  = ram_pkg::CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  ram_nrst,
   output logic                  ram_chipe,
   output logic                  ram_wre,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [CNT_WIDTH-1:0]  wr_cnt,
   output logic [CNT_WIDTH-1:0]  rd_cnt
);

   import ram_pkg::*;

   localparam int unsigned AW1 = ADDR_WIDTH + 1;

   // Command register sized by this instance's parameters rather than the package defaults.
   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } port_cmd_t;

   state_t    state;
   state_t    state_nxt;
   port_cmd_t cmd;
   logic      accept;
   logic      in_range;
   logic      wr_inc;
   logic      rd_inc;

   assign accept   = req_valid && (state == IDLE);
   assign in_range = {1'b0, req_addr} < AW1'(DEPTH);
   assign wr_inc   = (state == ISSUE) && cmd.we;
   assign rd_inc   = (state == RESP) && rsp_ready;

   assign ram_addr  = cmd.addr;
   assign ram_wdata = cmd.wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-state strobes.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_chipe = 1'b0;
      ram_wre   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = in_range ? ISSUE : ERR;
            end
         end
         ISSUE: begin
            ram_chipe = 1'b1;
            ram_wre   = cmd.we;
            state_nxt = cmd.we ? IDLE : CAPT;
         end
         CAPT: begin
            state_nxt = RESP;
         end
         ERR: begin
            state_nxt = cmd.we ? IDLE : RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd <= '0;
      end else if (accept) begin
         cmd <= '{we: req_we, addr: req_addr, wdata: req_wdata};
      end
   end

   // Response payload is only written on entry to RESP, so it stays frozen while back-pressured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state == CAPT) begin
         rsp_rdata <= ram_rdata;
         rsp_err   <= 1'b0;
      end else if ((state == ERR) && !cmd.we) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b1;
      end
   end

   // Held low through the first edge after release so the RAM sees a synchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_nrst <= 1'b0;
      end else begin
         ram_nrst <= 1'b1;
      end
   end

   stat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wr_inc),
      .count (wr_cnt)
   );

   stat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rd_inc),
      .count (rd_cnt)
   );

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: behavioural dual-port RAM, directed boundary steps and
// randomized traffic checked against an array/counter reference model.
module tb_ram_port_ctrl;

   localparam int unsigned DW     = 8;
   localparam int unsigned AW     = 3;
   localparam int unsigned DEPTH  = 6;
   localparam int unsigned CW     = 4;
   localparam int unsigned NWORDS = 8;
   localparam int unsigned CMOD   = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          ram_nrst;
   logic          ram_chipe;
   logic          ram_wre;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;

   // Port B of the RAM, driven directly by the bench.
   logic          pb_we = 1'b0;
   logic [AW-1:0] pb_addr = '0;
   logic [DW-1:0] pb_data = '0;

   logic [DW-1:0] mem [NWORDS] = '{default: '0};
   int            chipe_cnt = 0;

   logic [DW-1:0] model_mem [NWORDS] = '{default: '0};
   int            exp_wr = 0;
   int            exp_rd = 0;
   int            exp_chipe = 0;
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   ram_port_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ram_nrst  (ram_nrst),
      .ram_chipe (ram_chipe),
      .ram_wre   (ram_wre),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .wr_cnt    (wr_cnt),
      .rd_cnt    (rd_cnt)
   );

   // Synchronous RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (!ram_nrst) begin
         ram_rdata <= '0;
      end else if (ram_chipe && ram_wre) begin
         mem[ram_addr] <= ram_wdata;
      end else if (ram_chipe) begin
         ram_rdata <= mem[ram_addr];
      end
      if (pb_we) begin
         mem[pb_addr] <= pb_data;
      end
   end

   always @(posedge clk) begin
      if (ram_chipe) chipe_cnt <= chipe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a command and hold it until the accepting edge; returns #1 after that edge.
   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      while (!req_ready && n < 20) begin
         step();
         n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'(1));
      step();
      req_valid = 1'b0;
      if (32'(addr) < DEPTH) exp_chipe++;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int n = 0;
      send(1'b1, addr, data);
      while (!req_ready && n < 20) begin
         step();
         n++;
      end
      check("wr_ready_return", 32'(req_ready), 32'(1));
      if (32'(addr) < DEPTH) begin
         model_mem[addr] = data;
         exp_wr = (exp_wr + 1) % CMOD;
      end
      check("wr_mem", 32'(mem[addr]), 32'(model_mem[addr]));
      check("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
      check("wr_chipe_cnt", 32'(chipe_cnt), 32'(exp_chipe));
   endtask

   // Read with 'hold' cycles of back-pressure; optionally overwrite the same word via port B meanwhile.
   task automatic do_read(input logic [AW-1:0] addr, input int hold, input bit poke);
      int            n = 0;
      logic          inr;
      logic [DW-1:0] exp_data;
      inr      = 32'(addr) < DEPTH;
      exp_data = inr ? model_mem[addr] : '0;
      send(1'b0, addr, '0);
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      check("rsp_valid_wait", 32'(rsp_valid), 32'(1));
      for (int i = 0; i < hold; i++) begin
         if (poke && i == 0) begin
            pb_we   = 1'b1;
            pb_addr = addr;
            pb_data = 8'hFF;
            model_mem[addr] = 8'hFF;
         end
         step();
         pb_we = 1'b0;
         check("hold_rsp_valid", 32'(rsp_valid), 32'(1));
         check("hold_req_ready", 32'(req_ready), 32'(0));
         check("hold_rdata", 32'(rsp_rdata), 32'(exp_data));
         check("hold_chipe_cnt", 32'(chipe_cnt), 32'(exp_chipe));
      end
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
      check("rsp_err", 32'(rsp_err), 32'(!inr));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_rd = (exp_rd + 1) % CMOD;
      check("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
      check("post_rsp_valid", 32'(rsp_valid), 32'(0));
      check("post_req_ready", 32'(req_ready), 32'(1));
   endtask

   initial begin
      // Reset and release
      step();
      step();
      check("rst_nrst", 32'(ram_nrst), 32'(0));
      check("rst_wr_cnt", 32'(wr_cnt), 32'(0));
      rst = 1'b0;
      check("rel_nrst_low", 32'(ram_nrst), 32'(0));
      check("rel_req_ready", 32'(req_ready), 32'(1));
      check("rel_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rel_rdata", 32'(rsp_rdata), 32'(0));
      check("rel_err", 32'(rsp_err), 32'(0));
      check("rel_chipe", 32'(ram_chipe), 32'(0));
      step();
      check("rel_nrst_high", 32'(ram_nrst), 32'(1));

      // Write then read back
      do_write(3'd3, 8'hA5);
      do_read(3'd3, 0, 1'b0);
      check("wr_then_rd_wr_cnt", 32'(wr_cnt), 32'(1));
      check("wr_then_rd_rd_cnt", 32'(rd_cnt), 32'(1));

      // Back-pressure with a port-B overwrite of the word being returned
      do_write(3'd5, 8'h3C);
      do_read(3'd5, 10, 1'b1);

      // Out-of-range accesses
      do_write(3'd7, 8'h5A);
      check("oor_mem7", 32'(mem[7]), 32'(0));
      do_read(3'd6, 0, 1'b0);
      do_read(3'd7, 2, 1'b0);

      // Randomized traffic
      for (int k = 0; k < 60; k++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         a = AW'($urandom_range(0, NWORDS - 1));
         d = DW'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(a, d);
         else do_read(a, int'($urandom_range(0, 3)), 1'b0);
      end

      // Reset while a read sits in CAPT
      do_write(3'd2, 8'h69);
      send(1'b0, 3'd2, '0);
      step();
      check("capt_req_ready", 32'(req_ready), 32'(0));
      check("capt_rsp_valid", 32'(rsp_valid), 32'(0));
      rst = 1'b1;
      #1;
      check("mid_rst_nrst", 32'(ram_nrst), 32'(0));
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("mid_rst_chipe", 32'(ram_chipe), 32'(0));
      check("mid_rst_req_ready", 32'(req_ready), 32'(1));
      step();
      step();
      rst = 1'b0;
      exp_wr = 0;
      exp_rd = 0;
      check("mid_rel_wr_cnt", 32'(wr_cnt), 32'(0));
      check("mid_rel_rd_cnt", 32'(rd_cnt), 32'(0));
      for (int i = 0; i < 4; i++) begin
         step();
         check("mid_rel_rsp_valid", 32'(rsp_valid), 32'(0));
         check("mid_rel_req_ready", 32'(req_ready), 32'(1));
      end
      check("mid_rel_nrst", 32'(ram_nrst), 32'(1));
      do_read(3'd2, 1, 1'b0);

      // Counter wrap: 17 in-range writes on a 4-bit counter
      for (int k = 0; k < 17; k++) begin
         do_write(AW'(k % DEPTH), DW'(k * 7 + 1));
      end
      check("wr_wrap", 32'(wr_cnt), 32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
